// File: rtl/angle_reduce_scheduler.sv
// Round-robin scheduler sharing one mod-360 reduction/quadrant unit among NUM_REQ requesters.
// Optional macro ANGLE_REDUCE_BYPASS_EN: angles already below 360 skip the unit.
module angle_reduce_scheduler #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned ID_W        = 1,
  parameter int unsigned RED_LATENCY = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_angle,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          red_en,
  output logic [DATA_WIDTH-1:0]         red_angle,
  input  logic [DATA_WIDTH-1:0]         red_result,
  input  logic [1:0]                    red_quadrant,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [ID_W-1:0]               resp_id,
  output logic [DATA_WIDTH-1:0]         resp_angle,
  output logic [1:0]                    resp_quadrant,
  output logic                          busy
);

  localparam int unsigned CNT_W = (RED_LATENCY > 1) ? $clog2(RED_LATENCY) : 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StResp  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] red_angle_q, red_angle_d;
  logic [ID_W-1:0]       resp_id_q, resp_id_d;
  logic [DATA_WIDTH-1:0] resp_angle_q, resp_angle_d;
  logic [1:0]            resp_quadrant_q, resp_quadrant_d;

  logic                  grant_found;
  int unsigned           grant_idx;
  logic [DATA_WIDTH-1:0] sel_angle;

`ifdef ANGLE_REDUCE_BYPASS_EN
  function automatic logic [1:0] quad_of(input logic [DATA_WIDTH-1:0] a);
    if (a <= DATA_WIDTH'(90))       return 2'd0;
    else if (a <= DATA_WIDTH'(180)) return 2'd1;
    else if (a <= DATA_WIDTH'(270)) return 2'd2;
    else                            return 2'd3;
  endfunction
`endif

  // Scan downward so the smallest offset from rr_ptr wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 0;
    for (int unsigned k = NUM_REQ; k > 0; k--) begin
      if (req_valid[(32'(rr_ptr_q) + k - 1) % NUM_REQ]) begin
        grant_found = 1'b1;
        grant_idx   = (32'(rr_ptr_q) + k - 1) % NUM_REQ;
      end
    end
  end

  assign sel_angle = req_angle[grant_idx*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    req_ready = '0;
    if (reset_n && (state_q == StIdle) && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    cnt_d           = cnt_q;
    red_angle_d     = red_angle_q;
    resp_id_d       = resp_id_q;
    resp_angle_d    = resp_angle_q;
    resp_quadrant_d = resp_quadrant_q;
    unique case (state_q)
      StIdle: begin
        if (grant_found) begin
          red_angle_d = sel_angle;
          resp_id_d   = ID_W'(grant_idx);
          state_d     = StIssue;
`ifdef ANGLE_REDUCE_BYPASS_EN
          if (sel_angle < DATA_WIDTH'(360)) begin
            resp_angle_d    = sel_angle;
            resp_quadrant_d = quad_of(sel_angle);
            state_d         = StResp;
          end
`endif
        end
      end
      StIssue: begin
        cnt_d   = CNT_W'(RED_LATENCY - 1);
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q == '0) begin
          resp_angle_d    = red_result;
          resp_quadrant_d = red_quadrant;
          state_d         = StResp;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StResp: begin
        if (resp_ready) begin
          rr_ptr_d = ID_W'((32'(resp_id_q) + 1) % NUM_REQ);
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= StIdle;
      rr_ptr_q        <= '0;
      cnt_q           <= '0;
      red_angle_q     <= '0;
      resp_id_q       <= '0;
      resp_angle_q    <= '0;
      resp_quadrant_q <= '0;
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      cnt_q           <= cnt_d;
      red_angle_q     <= red_angle_d;
      resp_id_q       <= resp_id_d;
      resp_angle_q    <= resp_angle_d;
      resp_quadrant_q <= resp_quadrant_d;
    end
  end

  // The unit tristates when disabled, so enable spans ISSUE through the capture edge.
  assign red_en        = (state_q == StIssue) || (state_q == StWait);
  assign red_angle     = red_angle_q;
  assign resp_valid    = (state_q == StResp);
  assign resp_id       = resp_id_q;
  assign resp_angle    = resp_angle_q;
  assign resp_quadrant = resp_quadrant_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_angle_reduce_scheduler.sv
// Scoreboard bench for angle_reduce_scheduler with a behavioural reduction-unit model.
module tb_angle_reduce_scheduler;

  localparam int unsigned DW = 64;
  localparam int unsigned NR = 2;
  localparam int unsigned IW = 1;
  localparam int unsigned RL = 2;

`ifdef ANGLE_REDUCE_BYPASS_EN
  localparam int BYP_LAT = 1;
  localparam int BYP_EN  = 0;
`else
  localparam int BYP_LAT = RL + 1;
  localparam int BYP_EN  = RL + 1;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*DW-1:0]  req_angle = '0;
  logic [NR-1:0]     req_ready;
  logic              red_en;
  logic [DW-1:0]     red_angle;
  logic [DW-1:0]     red_result;
  logic [1:0]        red_quadrant;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [IW-1:0]     resp_id;
  logic [DW-1:0]     resp_angle;
  logic [1:0]        resp_quadrant;
  logic              busy;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] ang;
    logic [1:0]    q;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  angle_reduce_scheduler #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR),
    .ID_W       (IW),
    .RED_LATENCY(RL)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_angle    (req_angle),
    .req_ready    (req_ready),
    .red_en       (red_en),
    .red_angle    (red_angle),
    .red_result   (red_result),
    .red_quadrant (red_quadrant),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_angle   (resp_angle),
    .resp_quadrant(resp_quadrant),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] qmap(input logic [DW-1:0] a);
    if (a <= 64'd90)       return 2'd0;
    else if (a <= 64'd180) return 2'd1;
    else if (a <= 64'd270) return 2'd2;
    else                   return 2'd3;
  endfunction

  function automatic exp_t mk(input int id, input logic [DW-1:0] raw);
    exp_t e;
    e.id  = IW'(id);
    e.ang = raw % 64'd360;
    e.q   = qmap(e.ang);
    return e;
  endfunction

  // Reduction-unit model: outputs valid only after RL enabled edges, garbage otherwise.
  int en_cnt = 0;
  int en_total = 0;
  logic [DW-1:0] mod_angle;
  assign mod_angle    = red_angle % 64'd360;
  assign red_result   = (red_en && en_cnt >= RL) ? mod_angle : '1;
  assign red_quadrant = (red_en && en_cnt >= RL) ? qmap(mod_angle) : 2'b00;
  always @(posedge clk) en_cnt <= red_en ? en_cnt + 1 : 0;
  always @(negedge clk) if (red_en) en_total <= en_total + 1;

  task automatic wait_resp(input int budget, output int cycles);
    cycles = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk); #1;
      if (resp_valid) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; req_valid = '0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = 2'b11;
    req_angle[0 +: DW] = 64'd725; req_angle[DW +: DW] = 64'd33;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      errors++; $display("FAIL reset_ready got=%b exp=00", req_ready);
    end
    checks++;
    if (red_en !== 1'b0 || resp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl got en=%b rv=%b busy=%b exp 0 0 0", red_en, resp_valid, busy);
    end
    checks++;
    if (red_angle !== '0 || resp_id !== '0 || resp_angle !== '0 || resp_quadrant !== 2'd0) begin
      errors++; $display("FAIL reset_data got ra=%0d id=%0d a=%0d q=%0d exp all 0",
                         red_angle, resp_id, resp_angle, resp_quadrant);
    end
    req_valid = '0;
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    int cyc, en0;
    exp_t e;
    sb.delete();
    @(negedge clk);
    req_angle[0 +: DW] = 64'd725; req_valid = 2'b01;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL single_ready got=%b exp=01", req_ready);
    end
    sb.push_back(mk(0, 64'd725));
    en0 = en_total;
    @(posedge clk); #1 req_valid = '0;
    wait_resp(20, cyc);
    checks++;
    if (cyc != RL + 1) begin
      errors++; $display("FAIL single_latency got=%0d exp=%0d", cyc, RL + 1);
    end
    checks++;
    if (en_total - en0 != RL + 1) begin
      errors++; $display("FAIL single_en_cycles got=%0d exp=%0d", en_total - en0, RL + 1);
    end
    e = sb.pop_front();
    checks++;
    if (resp_id !== e.id || resp_angle !== e.ang || resp_quadrant !== e.q) begin
      errors++; $display("FAIL single_resp got id=%0d a=%0d q=%0d exp id=%0d a=%0d q=%0d",
                         resp_id, resp_angle, resp_quadrant, e.id, e.ang, e.q);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1 resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_release got rv=%b busy=%b exp 0 0", resp_valid, busy);
    end
  endtask

  task automatic test_round_robin();
    int cyc;
    exp_t e;
    do_reset();
    sb.delete();
    @(negedge clk);
    req_angle[0 +: DW] = 64'd450; req_angle[DW +: DW] = 64'd1000;
    req_valid = 2'b11; resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) sb.push_back(mk(i % 2, (i % 2 == 0) ? 64'd450 : 64'd1000));
    for (int i = 0; i < 4; i++) begin
      wait_resp(20, cyc);
      checks++;
      if (cyc < 0 || sb.size() == 0) begin
        errors++; $display("FAIL rr_timeout txn=%0d got=no response exp=response", i);
        break;
      end
      e = sb.pop_front();
      if (resp_id !== e.id || resp_angle !== e.ang || resp_quadrant !== e.q) begin
        errors++; $display("FAIL rr_resp txn=%0d got id=%0d a=%0d q=%0d exp id=%0d a=%0d q=%0d",
                           i, resp_id, resp_angle, resp_quadrant, e.id, e.ang, e.q);
      end
      if (i == 3) req_valid = '0;
    end
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rr_idle got busy=%b exp=0", busy);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    exp_t e;
    sb.delete();
    @(negedge clk);
    req_angle[0 +: DW] = 64'd540; req_valid = 2'b01;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL bp_ready got=%b exp=01", req_ready);
    end
    sb.push_back(mk(0, 64'd540));
    @(posedge clk); #1;
    req_angle[DW +: DW] = 64'd100; req_valid = 2'b11;
    wait_resp(20, cyc);
    e = sb.pop_front();
    checks++;
    if (cyc != RL + 1 || resp_id !== e.id || resp_angle !== e.ang || resp_quadrant !== e.q) begin
      errors++; $display("FAIL bp_resp got lat=%0d id=%0d a=%0d q=%0d exp lat=%0d id=%0d a=%0d q=%0d",
                         cyc, resp_id, resp_angle, resp_quadrant, RL + 1, e.id, e.ang, e.q);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_angle !== e.ang || resp_quadrant !== e.q ||
          resp_id !== e.id || req_ready !== 2'b00) begin
        errors++; $display("FAIL bp_hold cyc=%0d got rv=%b a=%0d q=%0d rdy=%b exp rv=1 a=%0d q=%0d rdy=00",
                           i, resp_valid, resp_angle, resp_quadrant, req_ready, e.ang, e.q);
      end
    end
    req_valid = '0; resp_ready = 1'b1;
    @(posedge clk); #1 resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_release got rv=%b busy=%b exp 0 0", resp_valid, busy);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    exp_t e;
    sb.delete();
    @(negedge clk);
    req_angle[DW +: DW] = 64'd1000; req_valid = 2'b10;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++; $display("FAIL mid_ready got=%b exp=10", req_ready);
    end
    @(posedge clk); #1 req_valid = '0;
    @(posedge clk); #1;
    checks++;
    if (red_en !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL mid_wait got en=%b busy=%b exp 1 1", red_en, busy);
    end
    reset_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (red_en !== 1'b0 || resp_valid !== 1'b0 || busy !== 1'b0 || red_angle !== '0 ||
        resp_id !== '0) begin
      errors++; $display("FAIL mid_reset got en=%b rv=%b busy=%b ra=%0d id=%0d exp all 0",
                         red_en, resp_valid, busy, red_angle, resp_id);
    end
    reset_n = 1'b1;
    @(negedge clk);
    req_angle[0 +: DW] = 64'd360; req_angle[DW +: DW] = 64'd5; req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL mid_rrptr got=%b exp=01", req_ready);
    end
    sb.push_back(mk(0, 64'd360));
    @(posedge clk); #1 req_valid = '0;
    wait_resp(20, cyc);
    e = sb.pop_front();
    checks++;
    if (cyc != RL + 1 || resp_id !== e.id || resp_angle !== e.ang || resp_quadrant !== e.q) begin
      errors++; $display("FAIL mid_resp got lat=%0d id=%0d a=%0d q=%0d exp lat=%0d id=%0d a=%0d q=%0d",
                         cyc, resp_id, resp_angle, resp_quadrant, RL + 1, e.id, e.ang, e.q);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1 resp_ready = 1'b0;
  endtask

  task automatic test_bypass();
    int cyc, en0;
    exp_t e;
    logic [DW-1:0] angs [2];
    angs[0] = 64'd200;
    angs[1] = 64'd1080;
    sb.delete();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      req_angle[0 +: DW] = angs[i]; req_valid = 2'b01;
      sb.push_back(mk(0, angs[i]));
      en0 = en_total;
      @(posedge clk); #1 req_valid = '0;
      wait_resp(20, cyc);
      e = sb.pop_front();
      checks++;
      if (cyc != ((i == 0) ? BYP_LAT : RL + 1) ||
          en_total - en0 != ((i == 0) ? BYP_EN : RL + 1)) begin
        errors++; $display("FAIL byp_timing angle=%0d got lat=%0d en=%0d exp lat=%0d en=%0d",
                           angs[i], cyc, en_total - en0, (i == 0) ? BYP_LAT : RL + 1,
                           (i == 0) ? BYP_EN : RL + 1);
      end
      checks++;
      if (resp_id !== e.id || resp_angle !== e.ang || resp_quadrant !== e.q) begin
        errors++; $display("FAIL byp_resp got id=%0d a=%0d q=%0d exp id=%0d a=%0d q=%0d",
                           resp_id, resp_angle, resp_quadrant, e.id, e.ang, e.q);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1 resp_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_bypass();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/angle_reduce_scheduler.md
Name: angle_reduce_scheduler

Overview:
Round-robin scheduler that shares the single mod-360 angle-reduction/quadrant unit among NUM_REQ trig requesters.
- Accepts one angle per transaction over valid/ready and drives the reduction unit's enable and input.
- Waits the unit's fixed latency, captures the reduced angle and quadrant, and returns them with the requester ID over a valid/ready response channel.
- Sits between the front-end request ports and the CORDIC/trig core.

Parameters:
- DATA_WIDTH, 64, angle word width (integer degrees).
- NUM_REQ, 2, number of requesters (2..8).
- ID_W, 1, width of requester ID; must be ≥ clog2(NUM_REQ).
- RED_LATENCY, 2, cycles from first enabled edge of reduction unit until both angle and quadrant outputs are stable.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_angle  in  NUM_REQ*DATA_WIDTH  packed angles; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  one-hot accept; combinational from state and req_valid.
- red_en  out  1  enable to reduction unit.
- red_angle  out  DATA_WIDTH  angle driven to reduction unit.
- red_result  in  DATA_WIDTH  reduced angle from unit.
- red_quadrant  in  2  quadrant from unit.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumer ready.
- resp_id  out  ID_W  index of the requester served.
- resp_angle  out  DATA_WIDTH  reduced angle (0..359).
- resp_quadrant  out  2  quadrant 0..3.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - state=IDLE, rr_ptr=0, wait counter=0.
  - red_en=0, red_angle=0, resp_valid=0, resp_id=0, resp_angle=0, resp_quadrant=0, busy=0.
  - req_ready is forced 0 while reset_n=0.
- FSM has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant = first i with req_valid[i]=1, searching from rr_ptr upward with wrap.
  - req_ready[grant]=1 in the same cycle; all other req_ready bits are 0.
  - On that edge: latch angle into red_angle, latch grant into resp_id, go to ISSUE.
  - If no request is valid, stay in IDLE.
- ISSUE (1 cycle):
  - red_en=1, red_angle held.
  - Next edge: counter=RED_LATENCY-1, go to WAIT.
- WAIT:
  - red_en held at 1 and red_angle held; the unit tristates its outputs when disabled, so enable must stay high until capture.
  - Counter decrements each cycle.
  - At the edge where counter==0: capture red_result into resp_angle and red_quadrant into resp_quadrant, drive red_en=0, set resp_valid=1, go to RESP.
- RESP:
  - resp_valid, resp_id, resp_angle and resp_quadrant held stable until resp_ready=1.
  - On the handshake edge: resp_valid=0, rr_ptr=(resp_id+1) mod NUM_REQ, go to IDLE.
- Latency: resp_valid rises RED_LATENCY+1 edges after the accept edge (3 with default).
- Throughput: one transaction in flight; minimum spacing RED_LATENCY+3 cycles.
- Simultaneous requests: exactly one grant per IDLE cycle. Losers keep req_valid asserted; they are not dropped.
- req_valid changing or deasserting outside the IDLE accept cycle has no effect.
- Reset mid-transaction (any state): the transaction is abandoned with no response, red_en drops on the reset edge, and all outputs return to reset values.
- resp_ready asserted while not in RESP is ignored.
- Quadrant mapping expected from the unit:
  - 0..90 → 0
  - 91..180 → 1
  - 181..270 → 2
  - 271..359 → 3
- Out-of-range quadrant or X/Z inputs are passed through unchanged; no error is signalled.

Optional Feature:
- Macro: ANGLE_REDUCE_BYPASS_EN.
- When defined, in IDLE the accepted angle is checked:
  - If angle < 360: skip ISSUE/WAIT and go directly to RESP on the next edge.
  - resp_angle = angle; resp_quadrant computed locally with the same mapping; red_en stays 0.
  - Latency is 1 edge after accept.
  - Angles ≥ 360 use the normal path.
- When undefined, every request uses the reduction unit and the local comparator logic is not present.

Test Plan:
1. req_valid=01, angle0=725, unit model RED_LATENCY=2 → req_ready=01 for 1 cycle; red_en high 3 cycles; resp_valid 3 edges after accept; resp_id=0, resp_angle=5, resp_quadrant=0.
2. req_valid=11 held with angles 450 and 1000, resp_ready=1 → served in order id0 (90, q0), id1 (280, q3), id0, id1; grants alternate.
3. Angle 540 with resp_ready=0 for 5 cycles → resp_valid stays 1 and resp_angle=180, resp_quadrant=1 stable; IDLE returns only after resp_ready=1; no second req_ready meanwhile.
4. Reset asserted in WAIT → next cycle red_en=0, resp_valid=0, busy=0, rr_ptr=0; new request for 360 → resp_angle=0, resp_quadrant=0.
5. With ANGLE_REDUCE_BYPASS_EN, angle 200 → resp_valid 1 edge after accept, resp_angle=200, resp_quadrant=2, red_en never high; angle 1080 → normal path, resp_angle=0, resp_quadrant=0.
